// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: word width and FSM state encoding.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_ram_array.sv
// Synchronous single-port word RAM with per-byte-lane write enable and registered read.
module dmem_ram_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        lane_en,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Read returns the old word on a write cycle; callers never use rdata after a write.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we && lane_en[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word request, fixed LATENCY, valid/ready response.
// Optional per-lane write enables via the DMEM_BYTE_EN_EN macro (adds the ByteEn port).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWE,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
`ifdef DMEM_BYTE_EN_EN
    input  logic [3:0]  ByteEn,
`endif
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] ReadData,
    output logic        RspErr
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1    = 4'(LATENCY - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_be;
    logic        rd_ok, err_q;

    logic        accept, going_resp;
    logic        src_we, src_err;
    logic [31:0] src_addr, src_wdata, offset;
    logic [3:0]  src_be, req_be;
    logic        ram_en, ram_we;
    logic [31:0] ram_rdata;

`ifdef DMEM_BYTE_EN_EN
    assign req_be = ByteEn;
`else
    assign req_be = 4'b1111;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        going_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (ReqValid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt  = S_RESP;
                        going_resp = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt  = S_RESP;
                    going_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (RspReady) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With LATENCY==1 the RAM access happens on the accept edge, so it must see the live request.
    always_comb begin
        if (state == S_IDLE) begin
            src_we    = ReqWE;
            src_addr  = Addr;
            src_wdata = WriteData;
            src_be    = req_be;
        end else begin
            src_we    = lat_we;
            src_addr  = lat_addr;
            src_wdata = lat_wdata;
            src_be    = lat_be;
        end
        offset  = src_addr - BASE_ADDR;
        src_err = (offset[1:0] != 2'b00) || ((offset >> 2) >= DEPTH_W32);
        ram_en  = reset && going_resp;
        ram_we  = ram_en && src_we && !src_err;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= 4'd0;
            rd_ok <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= LAT_M1;
                lat_we    <= ReqWE;
                lat_addr  <= Addr;
                lat_wdata <= WriteData;
                lat_be    <= req_be;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (going_resp) begin
                rd_ok <= !src_we && !src_err;
                err_q <= src_err;
            end else if (state == S_RESP && RspReady) begin
                rd_ok <= 1'b0;
                err_q <= 1'b0;
            end
        end
    end

    dmem_ram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk    (clk),
        .en     (ram_en),
        .we     (ram_we),
        .lane_en(src_be),
        .addr   (offset[AW+1:2]),
        .wdata  (src_wdata),
        .rdata  (ram_rdata)
    );

    assign ReqReady = (state == S_IDLE);
    assign RspValid = (state == S_RESP);
    assign RspErr   = err_q;
    assign ReadData = rd_ok ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters; byte lanes when DMEM_BYTE_EN_EN).
module tb_dmem_responder;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWE;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] ReadData;
    logic        RspErr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    dmem_responder #(
        .DEPTH_WORDS(64),
        .LATENCY    (LATENCY),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqWE    (ReqWE),
        .Addr     (Addr),
        .WriteData(WriteData),
`ifdef DMEM_BYTE_EN_EN
        .ByteEn   (ByteEn),
`endif
        .RspValid (RspValid),
        .RspReady (RspReady),
        .ReadData (ReadData),
        .RspErr   (RspErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request while the DUT is idle; it is accepted on the next edge.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        ReqWE     = we;
        Addr      = a;
        WriteData = d;
        ByteEn    = be;
        ReqValid  = 1'b1;
        tick();
        ReqValid  = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = -1;
        for (int k = 0; k < 20; k++) begin
            if (RspValid) begin
                n = k;
                break;
            end
            tick();
        end
    endtask

    task automatic complete();
        RspReady = 1'b1;
        tick();
        RspReady = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        issue(1'b1, a, d, be);
        wait_rsp(n);
        complete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (ReqReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_reqready: got %b expected 1", ReqReady); end
        checks++;
        if (RspValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rspvalid: got %b expected 0", RspValid); end
        checks++;
        if (ReadData !== 32'h0) begin errors++; $display("[TB] FAIL reset_readdata: got %h expected 00000000", ReadData); end
        checks++;
        if (RspErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsperr: got %b expected 0", RspErr); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        int n;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        wait_rsp(n);
        checks++;
        if (n !== LATENCY - 1) begin errors++; $display("[TB] FAIL wr_latency: got %0d expected %0d", n, LATENCY - 1); end
        checks++;
        if (RspErr !== 1'b0) begin errors++; $display("[TB] FAIL wr_err: got %b expected 0", RspErr); end
        checks++;
        if (ReadData !== 32'h0) begin errors++; $display("[TB] FAIL wr_readdata: got %h expected 00000000", ReadData); end
        checks++;
        if (ReqReady !== 1'b0) begin errors++; $display("[TB] FAIL wr_reqready: got %b expected 0", ReqReady); end
        complete();
        checks++;
        if (RspValid !== 1'b0 || ReqReady !== 1'b1) begin
            errors++; $display("[TB] FAIL wr_handshake: got valid=%b ready=%b expected valid=0 ready=1", RspValid, ReqReady);
        end
        issue(1'b0, 32'h10, 32'h0, 4'hF);
        wait_rsp(n);
        checks++;
        if (n !== LATENCY - 1) begin errors++; $display("[TB] FAIL rd_latency: got %0d expected %0d", n, LATENCY - 1); end
        checks++;
        if (ReadData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_data: got %h expected deadbeef", ReadData); end
        checks++;
        if (RspErr !== 1'b0) begin errors++; $display("[TB] FAIL rd_err: got %b expected 0", RspErr); end
        complete();
    endtask

    task automatic test_errors();
        int n;
        issue(1'b0, 32'h13, 32'h0, 4'hF);
        wait_rsp(n);
        checks++;
        if (RspErr !== 1'b1 || ReadData !== 32'h0) begin
            errors++; $display("[TB] FAIL misaligned_rd: got err=%b data=%h expected err=1 data=00000000", RspErr, ReadData);
        end
        complete();
        issue(1'b0, 32'h100, 32'h0, 4'hF);
        wait_rsp(n);
        checks++;
        if (RspErr !== 1'b1 || ReadData !== 32'h0) begin
            errors++; $display("[TB] FAIL range_rd: got err=%b data=%h expected err=1 data=00000000", RspErr, ReadData);
        end
        complete();
        issue(1'b1, 32'h13, 32'h0, 4'hF);
        wait_rsp(n);
        checks++;
        if (RspErr !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_wr: got %b expected 1", RspErr); end
        complete();
        issue(1'b0, 32'hFC, 32'h0, 4'hF);
        wait_rsp(n);
        checks++;
        if (RspErr !== 1'b0) begin errors++; $display("[TB] FAIL last_word_err: got %b expected 0", RspErr); end
        complete();
        issue(1'b0, 32'h10, 32'h0, 4'hF);
        wait_rsp(n);
        checks++;
        if (ReadData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ram_unchanged: got %h expected deadbeef", ReadData); end
        complete();
    endtask

    task automatic test_backpressure();
        int n;
        do_write(32'h20, 32'h12345678, 4'hF);
        issue(1'b0, 32'h20, 32'h0, 4'hF);
        wait_rsp(n);
        ReqWE    = 1'b0;
        Addr     = 32'h10;
        ReqValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (RspValid !== 1'b1 || ReadData !== 32'h12345678 || ReqReady !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got valid=%b data=%h ready=%b expected valid=1 data=12345678 ready=0",
                         k, RspValid, ReadData, ReqReady);
            end
            tick();
        end
        RspReady = 1'b1;
        tick();
        checks++;
        if (RspValid !== 1'b0 || ReqReady !== 1'b1) begin
            errors++; $display("[TB] FAIL hold_release: got valid=%b ready=%b expected valid=0 ready=1", RspValid, ReqReady);
        end
        tick();
        ReqValid = 1'b0;
        checks++;
        if (ReqReady !== 1'b0) begin errors++; $display("[TB] FAIL held_req_accept: got ready=%b expected 0", ReqReady); end
        wait_rsp(n);
        checks++;
        if (ReadData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL held_req_data: got %h expected deadbeef", ReadData); end
        tick();
        RspReady = 1'b0;
    endtask

    task automatic test_back_to_back();
        int a0, a1, n;
        RspReady = 1'b1;
        issue(1'b1, 32'h4, 32'hA5A5A5A5, 4'hF);
        a0 = cyc;
        ReqWE     = 1'b0;
        WriteData = 32'h0;
        ReqValid  = 1'b1;
        for (int k = 0; k < 20 && !ReqReady; k++) tick();
        tick();
        a1 = cyc;
        ReqValid = 1'b0;
        checks++;
        if (a1 - a0 !== LATENCY + 1) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", a1 - a0, LATENCY + 1); end
        wait_rsp(n);
        checks++;
        if (ReadData !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL b2b_data: got %h expected a5a5a5a5", ReadData); end
        tick();
        RspReady = 1'b0;
    endtask

    task automatic test_reset_midop();
        int n;
        do_write(32'h8, 32'h1, 4'hF);
        issue(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF);
        reset = 1'b0;
        tick();
        checks++;
        if (ReqReady !== 1'b1 || RspValid !== 1'b0 || ReadData !== 32'h0 || RspErr !== 1'b0) begin
            errors++; $display("[TB] FAIL midop_outputs: got ready=%b valid=%b data=%h err=%b expected 1 0 00000000 0",
                               ReqReady, RspValid, ReadData, RspErr);
        end
        reset = 1'b1;
        tick();
        issue(1'b0, 32'h8, 32'h0, 4'hF);
        wait_rsp(n);
        checks++;
        if (ReadData !== 32'h1) begin errors++; $display("[TB] FAIL midop_nowrite: got %h expected 00000001", ReadData); end
        complete();
    endtask

`ifdef DMEM_BYTE_EN_EN
    task automatic test_byte_en();
        int n;
        do_write(32'h0, 32'h11223344, 4'hF);
        do_write(32'h0, 32'hAABBCCDD, 4'b0101);
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        wait_rsp(n);
        checks++;
        if (ReadData !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL byte_lanes: got %h expected 11bb33dd", ReadData); end
        complete();
        do_write(32'h0, 32'hFFFFFFFF, 4'b0000);
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        wait_rsp(n);
        checks++;
        if (ReadData !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL byte_none: got %h expected 11bb33dd", ReadData); end
        complete();
    endtask
`endif

    initial begin
        reset     = 1'b0;
        ReqValid  = 1'b0;
        ReqWE     = 1'b0;
        Addr      = 32'h0;
        WriteData = 32'h0;
        ByteEn    = 4'hF;
        RspReady  = 1'b0;
        #1;
        test_reset();
        test_write_read();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
`ifdef DMEM_BYTE_EN_EN
        test_byte_en();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
